mc_control_fsm: RTL and testbench
=================================

Name: mc_control_fsm

Overview:
- Multi-cycle MIPS main control unit: sequences the shared datapath (PC, memory, IR, register file, ALU) one instruction at a time through fetch/decode/execute/memory/writeback states.
- Drives the 2-bit alu_op consumed by the ALU control decoder.
- Handshakes with a variable-latency unified memory via mem_ready.
- Traps on illegal opcodes and on memory timeout.

Parameters:
- MEM_TIMEOUT, 15, maximum consecutive wait cycles with mem_ready low in a memory state before bus-error trap. 0 disables the timeout. Range 0..255.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  6  IR[31:26], valid from DECODE onward
- mem_ready  in  1  memory completes the current access this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if ALU zero (beq)
- i_or_d  out  1  memory address select: 0=PC, 1=ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  IR load
- mem_to_reg  out  1  register write data select: 1=MDR, 0=ALUOut
- reg_dst  out  1  destination select: 1=rd, 0=rt
- reg_write  out  1  register file write enable
- alu_src_a  out  1  ALU A select: 0=PC, 1=regA
- alu_src_b  out  2  ALU B select: 00=regB, 01=4, 10=signext, 11=signext<<2
- alu_op  out  2  ALU operation class: 00=add, 01=sub/branch, 10=R-type funct
- pc_source  out  2  PC source: 00=ALU result, 01=ALUOut, 10=jump target
- state  out  4  current state encoding, for debug
- retire  out  1  one-cycle pulse when an instruction completes
- illegal_op  out  1  sticky; set when TRAP is entered from DECODE
- bus_error  out  1  sticky; set when TRAP is entered on memory timeout

Behaviour:
- Reset:
  - rst sampled high at a clock edge sets state=FETCH (0), clears wait_cnt, illegal_op, bus_error and retire.
  - Reset overrides every condition, including TRAP and a mid-access wait.
- Outputs: Moore decode of the state register, except that ir_write and pc_write in FETCH equal mem_ready. Any output not listed for a state is 0.
- State encodings and actions:
  - FETCH=0: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00, ir_write=pc_write=mem_ready. mem_ready=1 -> DECODE; otherwise stay.
  - DECODE=1: alu_src_a=0, alu_src_b=11, alu_op=00. Next state by opcode:
    - 100011 or 101011 -> MEM_ADDR
    - 000000 -> EXECUTE
    - 000100 -> BRANCH
    - 000010 -> JUMP
    - 001000 -> ADDI_EXEC
    - any other value -> TRAP, setting illegal_op
  - MEM_ADDR=2: alu_src_a=1, alu_src_b=10, alu_op=00. lw -> MEM_READ; sw -> MEM_WRITE.
  - MEM_READ=3: mem_read=1, i_or_d=1. mem_ready=1 -> MEM_WB.
  - MEM_WB=4: reg_write=1, mem_to_reg=1, reg_dst=0 -> FETCH.
  - MEM_WRITE=5: mem_write=1, i_or_d=1. mem_ready=1 -> FETCH.
  - EXECUTE=6: alu_src_a=1, alu_src_b=00, alu_op=10 -> R_WB.
  - R_WB=7: reg_write=1, reg_dst=1, mem_to_reg=0 -> FETCH.
  - BRANCH=8: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01 -> FETCH.
  - JUMP=9: pc_write=1, pc_source=10 -> FETCH.
  - ADDI_EXEC=10: alu_src_a=1, alu_src_b=10, alu_op=00 -> ADDI_WB.
  - ADDI_WB=11: reg_write=1, reg_dst=0, mem_to_reg=0 -> FETCH.
  - TRAP=15: all enables 0. Held until rst.
- Wait counter (8-bit):
  - Cleared on entry to FETCH, MEM_READ and MEM_WRITE.
  - Increments each cycle in those states while mem_ready=0.
  - With MEM_TIMEOUT>0: if mem_ready=0 and wait_cnt==MEM_TIMEOUT-1, next state is TRAP and bus_error is set.
  - mem_ready=1 in that same cycle takes priority; no trap occurs.
- retire: registered. It is high in the cycle after any transition into FETCH from MEM_WB, MEM_WRITE, R_WB, BRANCH, JUMP or ADDI_WB. It never pulses after reset or on TRAP entry.
- Latency with mem_ready held high, counting from FETCH:
  - R-type: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - beq, j: 3 cycles
  - addi: 4 cycles
  - Each memory wait cycle adds 1.
- opcode is sampled only in DECODE and MEM_ADDR; it may change in any other state without effect.

Test Plan:
- Reset: assert rst for 2 cycles mid-MEM_READ -> state=0, illegal_op=bus_error=retire=0. Next cycle shows mem_read=1, i_or_d=0, alu_src_b=01.
- R-type, opcode=000000, mem_ready=1 -> states 0,1,6,7,0. EXECUTE has alu_op=10. R_WB has reg_write=1, reg_dst=1. retire pulses once, 4 cycles after start.
- lw, opcode=100011, mem_ready low 2 cycles in MEM_READ -> states 0,1,2,3,3,3,4,0. MEM_WB has mem_to_reg=1, reg_write=1. Total 7 cycles.
- beq then j with mem_ready=1 -> BRANCH: alu_op=01, pc_write_cond=1, pc_source=01. JUMP: pc_write=1, pc_source=10. Each instruction takes 3 cycles.
- Illegal opcode=111111 -> DECODE goes to TRAP (15), illegal_op=1. Outputs stay 0 for 20 cycles despite mem_ready toggling. rst restores FETCH.
- Timeout, MEM_TIMEOUT=15, mem_ready held 0 in FETCH -> TRAP after exactly 15 cycles in FETCH, bus_error=1. Repeat with mem_ready=1 on the 15th cycle -> DECODE, no trap.

Source files
------------

// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multi-cycle MIPS main control FSM
// Sequences fetch/decode/execute/memory/writeback, with illegal-opcode and memory-timeout traps.
module mc_control_fsm #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic [3:0] state,
  output logic       retire,
  output logic       illegal_op,
  output logic       bus_error
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11,
    S_TRAP      = 4'd15
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     cur_state;
  state_t     nxt_state;
  logic [7:0] wait_cnt;
  logic       mem_state;
  logic       timeout;

  assign state = cur_state;

  always_comb begin
    nxt_state     = cur_state;
    mem_state     = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    case (cur_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        mem_state = 1'b1;
        if (mem_ready) nxt_state = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          6'b100011, 6'b101011: nxt_state = S_MEM_ADDR;
          6'b000000:            nxt_state = S_EXECUTE;
          6'b000100:            nxt_state = S_BRANCH;
          6'b000010:            nxt_state = S_JUMP;
          6'b001000:            nxt_state = S_ADDI_EXEC;
          default:              nxt_state = S_TRAP;
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        nxt_state = (opcode == 6'b100011) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        mem_read  = 1'b1;
        i_or_d    = 1'b1;
        mem_state = 1'b1;
        if (mem_ready) nxt_state = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        nxt_state  = S_FETCH;
      end
      S_MEM_WRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        mem_state = 1'b1;
        if (mem_ready) nxt_state = S_FETCH;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        nxt_state = S_R_WB;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        nxt_state = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        nxt_state     = S_FETCH;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        nxt_state = S_FETCH;
      end
      S_ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        nxt_state = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        reg_write = 1'b1;
        nxt_state = S_FETCH;
      end
      default: nxt_state = S_TRAP;
    endcase

    // a completing access in the last allowed cycle wins over the timeout
    timeout = (MEM_TIMEOUT > 0) && mem_state && !mem_ready && (wait_cnt == WAIT_LAST);
    if (timeout) nxt_state = S_TRAP;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state  <= S_FETCH;
      wait_cnt   <= 8'd0;
      retire     <= 1'b0;
      illegal_op <= 1'b0;
      bus_error  <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      if (nxt_state != cur_state) begin
        wait_cnt <= 8'd0;
      end else if (mem_state && !mem_ready) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
      // TRAP only leaves through reset, so any entry into FETCH from elsewhere is a completion
      retire <= (nxt_state == S_FETCH) && (cur_state != S_FETCH);
      if (cur_state == S_DECODE && nxt_state == S_TRAP) illegal_op <= 1'b1;
      if (timeout) bus_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb/tb_mc_control_fsm.sv - scoreboard bench for mc_control_fsm
// Driver plans each instruction's state walk and latency; monitor compares every cycle.
module tb_mc_control_fsm;

  logic       clk;
  logic       rst;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;
  logic       retire, illegal_op, bus_error;

  mc_control_fsm #(.MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .state(state), .retire(retire),
    .illegal_op(illegal_op), .bus_error(bus_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  st;
    logic [18:0] outs;
    logic        start;
  } rec_t;

  rec_t exp_q[$];
  int   lat_q[$];
  int   checks = 0;
  int   failures = 0;

  logic exp_retire = 1'b0;
  logic exp_ill = 1'b0;
  logic exp_be = 1'b0;
  logic mark_start = 1'b0;
  int   pend_lat = 0;

  localparam int K_R = 0, K_LW = 1, K_SW = 2, K_BEQ = 3, K_J = 4, K_ADDI = 5;

  function automatic logic [5:0] op_of(input int k);
    case (k)
      K_R:     return 6'b000000;
      K_LW:    return 6'b100011;
      K_SW:    return 6'b101011;
      K_BEQ:   return 6'b000100;
      K_J:     return 6'b000010;
      default: return 6'b001000;
    endcase
  endfunction

  function automatic int base_lat(input int k);
    case (k)
      K_LW:         return 5;
      K_R, K_SW:    return 4;
      K_BEQ, K_J:   return 3;
      default:      return 4;
    endcase
  endfunction

  // Control word per state straight from the state/action table.
  function automatic logic [15:0] ctl(input logic [3:0] st, input logic mr);
    logic pw, pwc, iod, mrd, mwr, irw, m2r, rd, rw, asa;
    logic [1:0] asb, aop, psrc;
    {pw, pwc, iod, mrd, mwr, irw, m2r, rd, rw, asa, asb, aop, psrc} = '0;
    case (st)
      4'd0:  begin mrd = 1; asb = 2'b01; irw = mr; pw = mr; end
      4'd1:  asb = 2'b11;
      4'd2:  begin asa = 1; asb = 2'b10; end
      4'd3:  begin mrd = 1; iod = 1; end
      4'd4:  begin rw = 1; m2r = 1; end
      4'd5:  begin mwr = 1; iod = 1; end
      4'd6:  begin asa = 1; aop = 2'b10; end
      4'd7:  begin rw = 1; rd = 1; end
      4'd8:  begin asa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; end
      4'd9:  begin pw = 1; psrc = 2'b10; end
      4'd10: begin asa = 1; asb = 2'b10; end
      4'd11: rw = 1;
      default: ;
    endcase
    return {pw, pwc, iod, mrd, mwr, irw, m2r, rd, rw, asa, asb, aop, psrc};
  endfunction

  task automatic cyc(input logic [3:0] st, input logic mr, input logic [5:0] op);
    rec_t r;
    @(negedge clk);
    mem_ready = mr;
    opcode    = op;
    r.st    = st;
    r.outs  = {ctl(st, mr), exp_retire, exp_ill, exp_be};
    r.start = mark_start;
    exp_q.push_back(r);
    exp_retire = 1'b0;
    mark_start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    mem_ready = 1'b0;
    exp_retire = 1'b0;
    exp_ill = 1'b0;
    exp_be = 1'b0;
    pend_lat = 0;
    cyc(4'd0, 1'b0, 6'($urandom));
    @(posedge clk);
    #1 rst = 1'b0;
    mark_start = 1'b1;
  endtask

  task automatic prologue(input int wf, input logic [5:0] op, input logic ok_fetch);
    if (pend_lat > 0) begin
      lat_q.push_back(pend_lat);
      exp_retire = 1'b1;
      pend_lat = 0;
    end
    for (int i = 0; i <= wf; i++) cyc(4'd0, (i == wf) && ok_fetch, 6'($urandom));
    if (ok_fetch) cyc(4'd1, 1'($urandom), op);
  endtask

  task automatic run_instr(input int k, input int wf, input int wm);
    logic [5:0] op;
    op = op_of(k);
    prologue(wf, op, 1'b1);
    case (k)
      K_R:   begin cyc(4'd6, 1'($urandom), 6'($urandom)); cyc(4'd7, 1'($urandom), 6'($urandom)); end
      K_LW:  begin
        cyc(4'd2, 1'($urandom), op);
        for (int i = 0; i <= wm; i++) cyc(4'd3, i == wm, 6'($urandom));
        cyc(4'd4, 1'($urandom), 6'($urandom));
      end
      K_SW:  begin
        cyc(4'd2, 1'($urandom), op);
        for (int i = 0; i <= wm; i++) cyc(4'd5, i == wm, 6'($urandom));
      end
      K_BEQ: cyc(4'd8, 1'($urandom), 6'($urandom));
      K_J:   cyc(4'd9, 1'($urandom), 6'($urandom));
      default: begin cyc(4'd10, 1'($urandom), 6'($urandom)); cyc(4'd11, 1'($urandom), 6'($urandom)); end
    endcase
    pend_lat = base_lat(k) + wf + (((k == K_LW) || (k == K_SW)) ? wm : 0);
  endtask

  task automatic trap_cycles(input int n);
    for (int i = 0; i < n; i++) cyc(4'd15, 1'($urandom), 6'($urandom));
  endtask

  function automatic logic [5:0] illegal_opcode();
    logic [5:0] v;
    do v = 6'($urandom);
    while (v == 6'b000000 || v == 6'b100011 || v == 6'b101011 ||
           v == 6'b000100 || v == 6'b000010 || v == 6'b001000);
    return v;
  endfunction

  // Monitor: one expected record per cycle, sampled mid-low-phase.
  initial begin : monitor
    rec_t r;
    logic [18:0] got;
    int cnum = 0;
    int start_c = 0;
    int lat;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        r = exp_q.pop_front();
        cnum++;
        got = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
               reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
               retire, illegal_op, bus_error};
        checks++;
        if (state !== r.st) begin
          failures++;
          $display("FAIL state cycle=%0d got=%0d exp=%0d", cnum, state, r.st);
        end
        checks++;
        if (got !== r.outs) begin
          failures++;
          $display("FAIL outputs cycle=%0d state=%0d got=%b exp=%b", cnum, r.st, got, r.outs);
        end
        if (r.start) start_c = cnum;
        if (retire === 1'b1) begin
          checks++;
          if (lat_q.size() == 0) begin
            failures++;
            $display("FAIL latency cycle=%0d got=unexpected_retire exp=no_retire", cnum);
          end else begin
            lat = lat_q.pop_front();
            if (cnum - start_c != lat) begin
              failures++;
              $display("FAIL latency cycle=%0d got=%0d exp=%0d", cnum, cnum - start_c, lat);
            end
          end
          start_c = cnum;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench timeout");
  end

  initial begin : driver
    int k;
    rst = 1'b1;
    opcode = 6'd0;
    mem_ready = 1'b0;
    do_reset();

    // reset while lw waits in MEM_READ
    prologue(0, op_of(K_LW), 1'b1);
    cyc(4'd2, 1'b1, op_of(K_LW));
    cyc(4'd3, 1'b0, 6'($urandom));
    cyc(4'd3, 1'b0, 6'($urandom));
    do_reset();

    run_instr(K_R, 0, 0);
    run_instr(K_LW, 0, 2);
    run_instr(K_BEQ, 0, 0);
    run_instr(K_J, 0, 0);
    run_instr(K_SW, 1, 1);
    run_instr(K_ADDI, 0, 0);

    // illegal opcode
    prologue(0, illegal_opcode(), 1'b1);
    exp_ill = 1'b1;
    trap_cycles(20);
    do_reset();

    // fetch timeout: 15 waiting cycles then TRAP
    prologue(14, 6'd0, 1'b0);
    exp_be = 1'b1;
    trap_cycles(5);
    do_reset();

    // ready on the last allowed cycle: no trap
    run_instr(K_J, 14, 0);
    run_instr(K_LW, 0, 14);
    run_instr(K_SW, 0, 14);

    // MEM_READ timeout
    prologue(0, op_of(K_LW), 1'b1);
    cyc(4'd2, 1'b0, op_of(K_LW));
    for (int i = 0; i < 15; i++) cyc(4'd3, 1'b0, 6'($urandom));
    exp_be = 1'b1;
    trap_cycles(4);
    do_reset();

    for (int n = 0; n < 150; n++) begin
      k = $urandom_range(0, 5);
      run_instr(k, $urandom_range(0, 3), $urandom_range(0, 3));
    end
    do_reset();

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    #5;
    checks++;
    if (exp_q.size() != 0 || lat_q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d/%0d exp=0/0", exp_q.size(), lat_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
